// File: rtl/maxi_reg_slice.sv
// maxi_reg_slice
//   Registered AXI4 master boundary between a core and the memory system.
//   Each of the five channels passes through a 2-entry skid buffer, so every
//   valid, ready and payload crossing the boundary comes from a flop. AW and AR
//   issue is throttled by live outstanding-transaction counters. W beats are
//   never throttled. The three interrupt lines get 2-flop synchronisers.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   MEI/MSI/MTI, irq_sync   async interrupt lines in, synchronised {MEI,MSI,MTI} out
//   s_aw*/s_w*/s_ar*        core-side request channels (core drives valid)
//   s_b*/s_r*               core-side response channels (slice drives valid)
//   MAXI_*                  memory-side AXI4 master port
//   wr_outstanding          AW issued minus B received
//   rd_outstanding          AR issued minus R bursts completed (rlast)
//   idle                    all slices empty and both counts zero

// Two-entry skid buffer: head register drives the downstream side, skid
// register catches the beat accepted in the cycle downstream stalls.
module maxi_skid #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] skid;
  logic         up_hs, dn_hs;
  logic         ld_head, ld_skid, head_from_skid;

  assign up_hs = up_valid & up_ready;
  assign dn_hs = dn_valid & dn_ready;

  // valid and ready are registered copies of the next state, so they never
  // depend combinationally on the far side of the slice
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= EMPTY;
      dn_valid <= 1'b0;
      up_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      dn_valid <= (state_nxt != EMPTY);
      up_ready <= (state_nxt != FULL);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (up_hs) state_nxt = ONE;
      ONE: begin
        if (up_hs && !dn_hs)      state_nxt = FULL;
        else if (!up_hs && dn_hs) state_nxt = EMPTY;
      end
      FULL:    if (dn_hs) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    ld_head        = 1'b0;
    ld_skid        = 1'b0;
    head_from_skid = 1'b0;
    case (state)
      EMPTY: ld_head = up_hs;
      ONE: begin
        ld_head = up_hs & dn_hs;
        ld_skid = up_hs & ~dn_hs;
      end
      FULL:    head_from_skid = dn_hs;
      default: ;
    endcase
  end

  // payload needs no reset: it is qualified by dn_valid
  always_ff @(posedge clock) begin
    if (head_from_skid) dn_data <= skid;
    else if (ld_head)   dn_data <= up_data;
    if (ld_skid)        skid    <= up_data;
  end
endmodule

// Outstanding counter, saturating at zero for unsolicited responses.
module maxi_ostd_cnt #(
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);
  assign at_max = (cnt == CNT_W'(MAX_OUT));

  always_ff @(posedge clock) begin
    if (reset)                          cnt <= '0;
    else if (inc && !dec)               cnt <= cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end
endmodule

module maxi_reg_slice #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 8,
  localparam int STRB_W = DATA_W / 8,
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MEI,
  input  logic              MSI,
  input  logic              MTI,
  output logic [2:0]        irq_sync,
  // core side
  input  logic [ID_W-1:0]   s_awid,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic [2:0]        s_awsize,
  input  logic [1:0]        s_awburst,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [STRB_W-1:0] s_wstrb,
  input  logic              s_wlast,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [ID_W-1:0]   s_bid,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  // memory side
  output logic [ID_W-1:0]   MAXI_awid,
  output logic [ADDR_W-1:0] MAXI_awaddr,
  output logic [7:0]        MAXI_awlen,
  output logic [2:0]        MAXI_awsize,
  output logic [1:0]        MAXI_awburst,
  output logic              MAXI_awvalid,
  input  logic              MAXI_awready,
  output logic [DATA_W-1:0] MAXI_wdata,
  output logic [STRB_W-1:0] MAXI_wstrb,
  output logic              MAXI_wlast,
  output logic              MAXI_wvalid,
  input  logic              MAXI_wready,
  input  logic [ID_W-1:0]   MAXI_bid,
  input  logic [1:0]        MAXI_bresp,
  input  logic              MAXI_bvalid,
  output logic              MAXI_bready,
  output logic [ID_W-1:0]   MAXI_arid,
  output logic [ADDR_W-1:0] MAXI_araddr,
  output logic [7:0]        MAXI_arlen,
  output logic [2:0]        MAXI_arsize,
  output logic [1:0]        MAXI_arburst,
  output logic              MAXI_arvalid,
  input  logic              MAXI_arready,
  input  logic [ID_W-1:0]   MAXI_rid,
  input  logic [DATA_W-1:0] MAXI_rdata,
  input  logic [1:0]        MAXI_rresp,
  input  logic              MAXI_rlast,
  input  logic              MAXI_rvalid,
  output logic              MAXI_rready,
  // status
  output logic [CNT_W-1:0]  wr_outstanding,
  output logic [CNT_W-1:0]  rd_outstanding,
  output logic              idle
);
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ax_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_t;

  ax_t  aw_up, aw_dn, ar_up, ar_dn;
  w_t   w_up, w_dn;
  b_t   b_up, b_dn;
  r_t   r_up, r_dn;
  logic aw_dn_valid, ar_dn_valid;
  logic wr_at_max, rd_at_max;

  // ---------------- AW ----------------
  assign aw_up = {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst};

  // at the limit the head entry stays put and is hidden from the bus
  maxi_skid #(.W($bits(ax_t))) u_aw (
    .clock(clock), .reset(reset),
    .up_valid(s_awvalid), .up_ready(s_awready), .up_data(aw_up),
    .dn_valid(aw_dn_valid), .dn_ready(MAXI_awready & ~wr_at_max), .dn_data(aw_dn)
  );

  assign MAXI_awvalid = aw_dn_valid & ~wr_at_max;
  assign MAXI_awid    = aw_dn.id;
  assign MAXI_awaddr  = aw_dn.addr;
  assign MAXI_awlen   = aw_dn.len;
  assign MAXI_awsize  = aw_dn.size;
  assign MAXI_awburst = aw_dn.burst;

  // ---------------- W ----------------
  assign w_up = {s_wdata, s_wstrb, s_wlast};

  maxi_skid #(.W($bits(w_t))) u_w (
    .clock(clock), .reset(reset),
    .up_valid(s_wvalid), .up_ready(s_wready), .up_data(w_up),
    .dn_valid(MAXI_wvalid), .dn_ready(MAXI_wready), .dn_data(w_dn)
  );

  assign MAXI_wdata = w_dn.data;
  assign MAXI_wstrb = w_dn.strb;
  assign MAXI_wlast = w_dn.last;

  // ---------------- B ----------------
  assign b_up = {MAXI_bid, MAXI_bresp};

  maxi_skid #(.W($bits(b_t))) u_b (
    .clock(clock), .reset(reset),
    .up_valid(MAXI_bvalid), .up_ready(MAXI_bready), .up_data(b_up),
    .dn_valid(s_bvalid), .dn_ready(s_bready), .dn_data(b_dn)
  );

  assign s_bid   = b_dn.id;
  assign s_bresp = b_dn.resp;

  // ---------------- AR ----------------
  assign ar_up = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst};

  maxi_skid #(.W($bits(ax_t))) u_ar (
    .clock(clock), .reset(reset),
    .up_valid(s_arvalid), .up_ready(s_arready), .up_data(ar_up),
    .dn_valid(ar_dn_valid), .dn_ready(MAXI_arready & ~rd_at_max), .dn_data(ar_dn)
  );

  assign MAXI_arvalid = ar_dn_valid & ~rd_at_max;
  assign MAXI_arid    = ar_dn.id;
  assign MAXI_araddr  = ar_dn.addr;
  assign MAXI_arlen   = ar_dn.len;
  assign MAXI_arsize  = ar_dn.size;
  assign MAXI_arburst = ar_dn.burst;

  // ---------------- R ----------------
  assign r_up = {MAXI_rid, MAXI_rdata, MAXI_rresp, MAXI_rlast};

  maxi_skid #(.W($bits(r_t))) u_r (
    .clock(clock), .reset(reset),
    .up_valid(MAXI_rvalid), .up_ready(MAXI_rready), .up_data(r_up),
    .dn_valid(s_rvalid), .dn_ready(s_rready), .dn_data(r_dn)
  );

  assign s_rid   = r_dn.id;
  assign s_rdata = r_dn.data;
  assign s_rresp = r_dn.resp;
  assign s_rlast = r_dn.last;

  // ---------------- outstanding counts ----------------
  maxi_ostd_cnt #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_wr_cnt (
    .clock(clock), .reset(reset),
    .inc(MAXI_awvalid & MAXI_awready),
    .dec(MAXI_bvalid & MAXI_bready),
    .cnt(wr_outstanding), .at_max(wr_at_max)
  );

  // a read is complete only on its last beat
  maxi_ostd_cnt #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_rd_cnt (
    .clock(clock), .reset(reset),
    .inc(MAXI_arvalid & MAXI_arready),
    .dec(MAXI_rvalid & MAXI_rready & MAXI_rlast),
    .cnt(rd_outstanding), .at_max(rd_at_max)
  );

  // ---------------- interrupts ----------------
  logic [1:0][2:0] irq_pipe;

  always_ff @(posedge clock) begin
    if (reset) irq_pipe <= '0;
    else       irq_pipe <= {irq_pipe[0], MEI, MSI, MTI};
  end

  assign irq_sync = irq_pipe[1];

  // a slice is empty exactly when its registered output valid is low
  assign idle = ~(aw_dn_valid | MAXI_wvalid | s_bvalid | ar_dn_valid | s_rvalid)
              & (wr_outstanding == '0) & (rd_outstanding == '0);
endmodule

// File: tb/tb_maxi_reg_slice.sv
module tb_maxi_reg_slice;
  localparam int AW = 32, DW = 64, IW = 4, SW = DW / 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // shared stimulus
  logic MEI, MSI, MTI;
  logic [IW-1:0] s_awid, s_arid, MAXI_bid, MAXI_rid;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [7:0]    s_awlen, s_arlen;
  logic [2:0]    s_awsize, s_arsize;
  logic [1:0]    s_awburst, s_arburst, MAXI_bresp, MAXI_rresp;
  logic          s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready;
  logic [DW-1:0] s_wdata, MAXI_rdata;
  logic [SW-1:0] s_wstrb;
  logic          MAXI_awready, MAXI_wready, MAXI_bvalid, MAXI_arready, MAXI_rlast, MAXI_rvalid;

  // main DUT (MAX_OUT=8) outputs
  logic [2:0]    irq_sync;
  logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
  logic [IW-1:0] s_bid, s_rid, MAXI_awid, MAXI_arid;
  logic [1:0]    s_bresp, s_rresp, MAXI_awburst, MAXI_arburst;
  logic [DW-1:0] s_rdata, MAXI_wdata;
  logic [AW-1:0] MAXI_awaddr, MAXI_araddr;
  logic [7:0]    MAXI_awlen, MAXI_arlen;
  logic [2:0]    MAXI_awsize, MAXI_arsize;
  logic          MAXI_awvalid, MAXI_wvalid, MAXI_wlast, MAXI_bready, MAXI_arvalid, MAXI_rready;
  logic [SW-1:0] MAXI_wstrb;
  logic [3:0]    wr_outstanding, rd_outstanding;
  logic          idle;

  // second DUT (MAX_OUT=2) outputs
  logic [2:0]    irq_sync2;
  logic          s_awready2, s_wready2, s_bvalid2, s_arready2, s_rvalid2, s_rlast2;
  logic [IW-1:0] s_bid2, s_rid2, MAXI_awid2, MAXI_arid2;
  logic [1:0]    s_bresp2, s_rresp2, MAXI_awburst2, MAXI_arburst2;
  logic [DW-1:0] s_rdata2, MAXI_wdata2;
  logic [AW-1:0] MAXI_awaddr2, MAXI_araddr2;
  logic [7:0]    MAXI_awlen2, MAXI_arlen2;
  logic [2:0]    MAXI_awsize2, MAXI_arsize2;
  logic          MAXI_awvalid2, MAXI_wvalid2, MAXI_wlast2, MAXI_bready2, MAXI_arvalid2, MAXI_rready2;
  logic [SW-1:0] MAXI_wstrb2;
  logic [1:0]    wr_outstanding2, rd_outstanding2;
  logic          idle2;

  maxi_reg_slice #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUT(8)) dut (
    .clock(clock), .reset(reset), .MEI(MEI), .MSI(MSI), .MTI(MTI), .irq_sync(irq_sync),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .MAXI_awid(MAXI_awid), .MAXI_awaddr(MAXI_awaddr), .MAXI_awlen(MAXI_awlen),
    .MAXI_awsize(MAXI_awsize), .MAXI_awburst(MAXI_awburst), .MAXI_awvalid(MAXI_awvalid),
    .MAXI_awready(MAXI_awready), .MAXI_wdata(MAXI_wdata), .MAXI_wstrb(MAXI_wstrb),
    .MAXI_wlast(MAXI_wlast), .MAXI_wvalid(MAXI_wvalid), .MAXI_wready(MAXI_wready),
    .MAXI_bid(MAXI_bid), .MAXI_bresp(MAXI_bresp), .MAXI_bvalid(MAXI_bvalid), .MAXI_bready(MAXI_bready),
    .MAXI_arid(MAXI_arid), .MAXI_araddr(MAXI_araddr), .MAXI_arlen(MAXI_arlen),
    .MAXI_arsize(MAXI_arsize), .MAXI_arburst(MAXI_arburst), .MAXI_arvalid(MAXI_arvalid),
    .MAXI_arready(MAXI_arready), .MAXI_rid(MAXI_rid), .MAXI_rdata(MAXI_rdata),
    .MAXI_rresp(MAXI_rresp), .MAXI_rlast(MAXI_rlast), .MAXI_rvalid(MAXI_rvalid),
    .MAXI_rready(MAXI_rready),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding), .idle(idle)
  );

  maxi_reg_slice #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUT(2)) dut2 (
    .clock(clock), .reset(reset), .MEI(MEI), .MSI(MSI), .MTI(MTI), .irq_sync(irq_sync2),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready2),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready2),
    .s_bid(s_bid2), .s_bresp(s_bresp2), .s_bvalid(s_bvalid2), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready2),
    .s_rid(s_rid2), .s_rdata(s_rdata2), .s_rresp(s_rresp2), .s_rlast(s_rlast2),
    .s_rvalid(s_rvalid2), .s_rready(s_rready),
    .MAXI_awid(MAXI_awid2), .MAXI_awaddr(MAXI_awaddr2), .MAXI_awlen(MAXI_awlen2),
    .MAXI_awsize(MAXI_awsize2), .MAXI_awburst(MAXI_awburst2), .MAXI_awvalid(MAXI_awvalid2),
    .MAXI_awready(MAXI_awready), .MAXI_wdata(MAXI_wdata2), .MAXI_wstrb(MAXI_wstrb2),
    .MAXI_wlast(MAXI_wlast2), .MAXI_wvalid(MAXI_wvalid2), .MAXI_wready(MAXI_wready),
    .MAXI_bid(MAXI_bid), .MAXI_bresp(MAXI_bresp), .MAXI_bvalid(MAXI_bvalid), .MAXI_bready(MAXI_bready2),
    .MAXI_arid(MAXI_arid2), .MAXI_araddr(MAXI_araddr2), .MAXI_arlen(MAXI_arlen2),
    .MAXI_arsize(MAXI_arsize2), .MAXI_arburst(MAXI_arburst2), .MAXI_arvalid(MAXI_arvalid2),
    .MAXI_arready(MAXI_arready), .MAXI_rid(MAXI_rid), .MAXI_rdata(MAXI_rdata),
    .MAXI_rresp(MAXI_rresp), .MAXI_rlast(MAXI_rlast), .MAXI_rvalid(MAXI_rvalid),
    .MAXI_rready(MAXI_rready2),
    .wr_outstanding(wr_outstanding2), .rd_outstanding(rd_outstanding2), .idle(idle2)
  );

  int passed = 0, total = 0, n_rout = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard: expectations pushed on the entry handshake, popped on exit
  logic [79:0] q_aw[$], q_w[$], q_b[$], q_ar[$], q_r[$];

  always @(negedge clock) begin
    if (reset) begin
      q_aw.delete(); q_w.delete(); q_b.delete(); q_ar.delete(); q_r.delete();
    end else begin
      if (s_awvalid && s_awready)     q_aw.push_back(80'({s_awid, s_awaddr}));
      if (s_wvalid && s_wready)       q_w.push_back(80'({s_wdata, s_wlast}));
      if (MAXI_bvalid && MAXI_bready) q_b.push_back(80'({MAXI_bid, MAXI_bresp}));
      if (s_arvalid && s_arready)     q_ar.push_back(80'({s_arid, s_araddr}));
      if (MAXI_rvalid && MAXI_rready) q_r.push_back(80'({MAXI_rid, MAXI_rresp, MAXI_rlast, MAXI_rdata}));
      if (MAXI_awvalid && MAXI_awready) begin
        if (q_aw.size() == 0) chk("aw_unexpected", 80'(MAXI_awaddr), 80'hx);
        else chk("aw_order", 80'({MAXI_awid, MAXI_awaddr}), q_aw.pop_front());
      end
      if (MAXI_wvalid && MAXI_wready) begin
        if (q_w.size() == 0) chk("w_unexpected", 80'(MAXI_wdata), 80'hx);
        else chk("w_order", 80'({MAXI_wdata, MAXI_wlast}), q_w.pop_front());
      end
      if (s_bvalid && s_bready) begin
        if (q_b.size() == 0) chk("b_unexpected", 80'(s_bid), 80'hx);
        else chk("b_pass", 80'({s_bid, s_bresp}), q_b.pop_front());
      end
      if (MAXI_arvalid && MAXI_arready) begin
        if (q_ar.size() == 0) chk("ar_unexpected", 80'(MAXI_araddr), 80'hx);
        else chk("ar_order", 80'({MAXI_arid, MAXI_araddr}), q_ar.pop_front());
      end
      if (s_rvalid && s_rready) begin
        n_rout++;
        if (q_r.size() == 0) chk("r_unexpected", 80'(s_rdata), 80'hx);
        else chk("r_pass", 80'({s_rid, s_rresp, s_rlast, s_rdata}), q_r.pop_front());
      end
    end
  end

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } r_vec_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic [3:0]    exp_wr;  // wr_outstanding after this B handshake
  } b_vec_t;

  r_vec_t r_tab[6];
  b_vec_t b_tab[4];

  initial begin
    int k, cyc, saved;
    logic hs;

    r_tab[0] = '{4'h2, 64'h11, 2'd0, 1'b0};
    r_tab[1] = '{4'h2, 64'h22, 2'd1, 1'b0};
    r_tab[2] = '{4'h2, 64'h33, 2'd2, 1'b0};
    r_tab[3] = '{4'h2, 64'h44, 2'd3, 1'b1};
    r_tab[4] = '{4'h7, 64'h55, 2'd0, 1'b1};
    r_tab[5] = '{4'hc, 64'h66, 2'd3, 1'b1};
    b_tab[0] = '{4'h3, 2'd0, 4'd1};
    b_tab[1] = '{4'h5, 2'd1, 4'd0};
    b_tab[2] = '{4'h9, 2'd2, 4'd0};
    b_tab[3] = '{4'ha, 2'd3, 4'd0};

    reset = 1'b1;
    {MEI, MSI, MTI} = 3'b000;
    s_awid = '0; s_awaddr = '0; s_awlen = 8'd0; s_awsize = 3'd3; s_awburst = 2'd1; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '1; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
    s_arid = '0; s_araddr = '0; s_arlen = 8'd3; s_arsize = 3'd3; s_arburst = 2'd1; s_arvalid = 1'b0;
    s_rready = 1'b1;
    MAXI_awready = 1'b1; MAXI_wready = 1'b1; MAXI_arready = 1'b1;
    MAXI_bid = '0; MAXI_bresp = '0; MAXI_bvalid = 1'b0;
    MAXI_rid = '0; MAXI_rdata = '0; MAXI_rresp = '0; MAXI_rlast = 1'b0; MAXI_rvalid = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_s_awready", 80'(s_awready), 80'(0));
    chk("rst_maxi_bready", 80'(MAXI_bready), 80'(0));
    chk("rst_maxi_rready", 80'(MAXI_rready), 80'(0));
    chk("rst_s_rvalid", 80'(s_rvalid), 80'(0));
    chk("rst_counts", 80'({wr_outstanding, rd_outstanding}), 80'(0));
    chk("rst_irq", 80'(irq_sync), 80'(0));
    reset = 1'b0;
    tick();
    chk("post_rst_readies", 80'({s_awready, s_wready, s_arready, MAXI_bready, MAXI_rready}), 80'(5'h1f));
    chk("post_rst_idle", 80'(idle), 80'(1));

    // back-to-back AR, one beat per cycle
    s_arvalid = 1'b1; s_arid = 4'h1; s_araddr = 32'h8000_0000;
    tick();
    chk("ar_c1_valid", 80'(MAXI_arvalid), 80'(1));
    chk("ar_c1_addr", 80'(MAXI_araddr), 80'(32'h8000_0000));
    s_araddr = 32'h8000_0040;
    tick();
    chk("ar_c2_valid", 80'(MAXI_arvalid), 80'(1));
    chk("ar_c2_addr", 80'(MAXI_araddr), 80'(32'h8000_0040));
    s_arvalid = 1'b0;
    tick();
    chk("ar_drained", 80'(MAXI_arvalid), 80'(0));
    chk("rd_out_2", 80'(rd_outstanding), 80'(2));

    // 4-beat R burst with the core stalling for 4 cycles
    s_rready = 1'b0; k = 0; cyc = 0;
    while (k < 4 && cyc < 30) begin
      MAXI_rvalid = 1'b1;
      MAXI_rid = r_tab[k].id; MAXI_rdata = r_tab[k].data;
      MAXI_rresp = r_tab[k].resp; MAXI_rlast = r_tab[k].last;
      if (cyc == 2) begin
        chk("r_full_backpressure", 80'(MAXI_rready), 80'(0));
        chk("r_buffered_beats", 80'(k), 80'(2));
      end
      if (cyc == 4) s_rready = 1'b1;
      hs = MAXI_rready;
      tick();
      cyc++;
      if (hs) k++;
    end
    MAXI_rvalid = 1'b0; MAXI_rlast = 1'b0;
    chk("r_burst_accepted", 80'(k), 80'(4));
    cyc = 0;
    while (n_rout < 4 && cyc < 10) begin tick(); cyc++; end
    tick();
    chk("r_burst_delivered", 80'(n_rout), 80'(4));
    chk("r_sb_empty", 80'(q_r.size()), 80'(0));
    chk("rd_out_after_rlast", 80'(rd_outstanding), 80'(1));

    // bring read count to 3, then AR issue and rlast in the same cycle
    s_arvalid = 1'b1; s_arid = 4'h3; s_araddr = 32'h0000_1000;
    tick();
    s_araddr = 32'h0000_2000;
    tick();
    s_arvalid = 1'b0;
    tick();
    chk("rd_out_3", 80'(rd_outstanding), 80'(3));
    s_arvalid = 1'b1; s_araddr = 32'h0000_3000;
    tick();
    s_arvalid = 1'b0;
    chk("ar_same_cycle_valid", 80'(MAXI_arvalid), 80'(1));
    MAXI_rvalid = 1'b1; MAXI_rid = r_tab[4].id; MAXI_rdata = r_tab[4].data;
    MAXI_rresp = r_tab[4].resp; MAXI_rlast = r_tab[4].last;
    chk("r_same_cycle_ready", 80'(MAXI_rready), 80'(1));
    tick();
    MAXI_rvalid = 1'b0; MAXI_rlast = 1'b0;
    chk("rd_out_same_cycle", 80'(rd_outstanding), 80'(3));
    tick(); tick();

    // reset with 2 beats held in the R slice
    s_rready = 1'b0;
    MAXI_rvalid = 1'b1; MAXI_rid = 4'h1; MAXI_rresp = 2'd0; MAXI_rlast = 1'b0;
    MAXI_rdata = 64'ha1;
    tick();
    MAXI_rdata = 64'ha2;
    tick();
    MAXI_rvalid = 1'b0;
    chk("r_two_buffered", 80'({s_rvalid, MAXI_rready}), 80'(2'b10));
    saved = n_rout;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_maxi_rready", 80'(MAXI_rready), 80'(0));
    chk("midrst_s_rvalid", 80'(s_rvalid), 80'(0));
    chk("midrst_counts", 80'({wr_outstanding, rd_outstanding}), 80'(0));
    s_rready = 1'b1;
    tick();
    chk("midrst_idle", 80'(idle), 80'(1));
    chk("midrst_ready_back", 80'(MAXI_rready), 80'(1));
    tick(); tick();
    chk("midrst_no_replay", 80'(n_rout), 80'(saved));

    // unsolicited R with rd count 0 passes through, count stays 0
    MAXI_rvalid = 1'b1; MAXI_rid = r_tab[5].id; MAXI_rdata = r_tab[5].data;
    MAXI_rresp = r_tab[5].resp; MAXI_rlast = r_tab[5].last;
    tick();
    MAXI_rvalid = 1'b0; MAXI_rlast = 1'b0;
    tick(); tick();
    chk("r_unsolicited_out", 80'(n_rout), 80'(saved + 1));
    chk("rd_out_sat0", 80'(rd_outstanding), 80'(0));

    // write limit on dut2 (MAX_OUT=2)
    s_awvalid = 1'b1; s_awid = 4'h1; s_awaddr = 32'h100;
    tick();
    s_awid = 4'h2; s_awaddr = 32'h200;
    tick();
    chk("lim_wr_1", 80'(wr_outstanding2), 80'(1));
    s_awid = 4'h3; s_awaddr = 32'h300;
    tick();
    s_awvalid = 1'b0;
    chk("lim_wr_2", 80'(wr_outstanding2), 80'(2));
    chk("lim_aw3_masked", 80'(MAXI_awvalid2), 80'(0));
    s_wvalid = 1'b1; s_wdata = 64'hdead_beef; s_wlast = 1'b1;
    tick();
    s_wvalid = 1'b0; s_wlast = 1'b0;
    chk("lim_aw3_still_masked", 80'(MAXI_awvalid2), 80'(0));
    chk("lim_wr_held", 80'(wr_outstanding2), 80'(2));
    chk("lim_w_not_throttled", 80'({MAXI_wvalid2, MAXI_wdata2}), 80'({1'b1, 64'hdead_beef}));
    MAXI_bvalid = 1'b1; MAXI_bid = 4'h1; MAXI_bresp = 2'd0;
    tick();
    MAXI_bvalid = 1'b0;
    chk("lim_wr_after_b", 80'(wr_outstanding2), 80'(1));
    chk("lim_aw3_released", 80'({MAXI_awvalid2, MAXI_awaddr2}), 80'({1'b1, 32'h300}));
    tick();
    chk("lim_wr_after_aw3", 80'(wr_outstanding2), 80'(2));
    chk("lim_aw3_gone", 80'(MAXI_awvalid2), 80'(0));

    // main dut: AW issue and B in the same cycle leaves the count unchanged
    chk("wr_out_2", 80'(wr_outstanding), 80'(2));
    s_awvalid = 1'b1; s_awid = 4'h4; s_awaddr = 32'h400;
    tick();
    s_awvalid = 1'b0;
    chk("wr_same_cycle_aw", 80'(MAXI_awvalid), 80'(1));
    MAXI_bvalid = 1'b1; MAXI_bid = 4'h2; MAXI_bresp = 2'd0;
    tick();
    chk("wr_out_same_cycle", 80'(wr_outstanding), 80'(2));

    // B table: resp codes pass through, count saturates at 0
    for (int i = 0; i < 4; i++) begin
      MAXI_bvalid = 1'b1; MAXI_bid = b_tab[i].id; MAXI_bresp = b_tab[i].resp;
      tick();
      chk($sformatf("b_tab%0d_wr", i), 80'(wr_outstanding), 80'(b_tab[i].exp_wr));
    end
    MAXI_bvalid = 1'b0;
    repeat (4) tick();
    chk("b_sb_empty", 80'(q_b.size()), 80'(0));

    // MTI pulse through the synchroniser
    MTI = 1'b1;
    tick();
    MTI = 1'b0;
    chk("irq_lat1", 80'(irq_sync), 80'(0));
    tick();
    chk("irq_lat2", 80'(irq_sync), 80'(3'b001));
    chk("irq_lat2_dut2", 80'(irq_sync2), 80'(3'b001));
    tick();
    chk("irq_one_cycle", 80'(irq_sync), 80'(0));

    repeat (4) tick();
    chk("sb_all_empty", 80'(q_aw.size() + q_w.size() + q_ar.size() + q_r.size()), 80'(0));
    chk("end_idle", 80'({idle, idle2}), 80'(2'b11));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
